uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one UART transmit path, the TX FIFO write port feeding the transmitter, among N_REQ byte-stream requesters.
Grants the FIFO to one requester at a time for a whole packet, with round-robin fairness. Streams that requester's bytes into the FIFO under full-flag backpressure.
Sits between client blocks (debug dumper, register reader, echo path) and the TX FIFO interface instance.

Parameters:
N_REQ, 4, number of requesters (2..16)
TIMEOUT, 1024, cycles a granted requester may hold req low mid-packet before the grant is revoked (>=2)
ID_W, $clog2(N_REQ), width of the requester index (derived, not overridden)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
req  in  N_REQ  per-requester byte valid; a packet is open from first accepted byte until last
req_data  in  8*N_REQ  byte from requester i in bits [8i+7:8i]
req_last  in  N_REQ  qualifies the current byte of requester i as final byte of its packet
ack  out  N_REQ  byte from requester i accepted this cycle (combinational)
grant  out  N_REQ  one-hot registered owner of the FIFO, 0 when idle
fifo_write_flag  out  1  write strobe to TX FIFO (combinational)
fifo_data_in  out  8  byte to TX FIFO
fifo_full_flag  in  1  TX FIFO full
busy  out  1  state != IDLE
abort  out  1  one-cycle registered pulse when a grant is revoked by timeout

Behaviour:
- Reset values: state IDLE, grant 0, busy 0, abort 0, ack 0, fifo_write_flag 0, fifo_data_in 0, rr pointer = N_REQ-1 so requester 0 wins first, timeout counter 0.
- States: IDLE, HEADER (only with the optional feature), STREAM.
- IDLE:
  - If any req bit is high, select the winner with round robin starting at pointer+1, wrapping.
  - Register the one-hot grant and enter STREAM next cycle; no byte moves in the selection cycle.
  - Minimum latency from req to first ack is 1 cycle.
- STREAM, owner g:
  - ack[g] = fifo_write_flag = req[g] & ~fifo_full_flag.
  - fifo_data_in = req_data slice g while the owner is valid, else hold the last value.
  - ack for non-owners is always 0.
- Packet end: on ack[g] & req_last[g], the next state is IDLE, pointer <= g, grant <= 0.
  - The next arbitration takes place in that IDLE cycle, giving a 1-cycle bubble between packets.
- Full handling: fifo_full_flag high stalls with no write and no ack; the grant is held indefinitely. Full never counts toward timeout.
- Timeout counter:
  - Increments each STREAM cycle with req[g]=0.
  - Clears on any ack and on entering STREAM.
  - At count == TIMEOUT-1 with req[g] still 0: grant <= 0, state <= IDLE, pointer <= g, abort pulses 1 cycle.
  - The partial packet stays in the FIFO; no recovery byte is inserted.
- Requests changing while not granted are ignored. A requester deasserting req before grant simply loses its turn.
- A single-byte packet has req_last set on its first byte.
- Reset mid-packet: all outputs return to reset values asynchronously; any partially written packet is not cleaned.

Optional Feature:
UART_ARB_HEADER_EN
- Defined:
  - The state after IDLE is HEADER. It writes header byte 8'hA0 | g (zero-extended id) when fifo_full_flag=0, with ack all 0, then enters STREAM.
  - A full FIFO stalls HEADER; the timeout counter is inactive in HEADER.
  - Latency from req to first payload ack is at least 2 cycles.
- Undefined: no HEADER state; the payload is written directly.

Decomposition:
- Shared include (uart_arb_defs): state encodings, HDR_MARK = 8'hA0, ID_W helper.
- One sub-module: rr_priority_picker (N_REQ req vector plus pointer in, one-hot winner and index out, purely combinational).

Test Plan:
- Single requester: req0 sends 3 bytes 0x11,0x22,0x33 with last on 0x33, FIFO never full -> fifo_write_flag high 3 consecutive cycles with those bytes, grant 0001 then 0, busy falls the cycle after 0x33.
- Round robin: req0 and req2 held continuously, 2-byte packets each -> packet order 0,2,0,2; with req1 added, order 0,1,2,0.
- Backpressure: fifo_full_flag high for 5 cycles mid-packet -> no ack and no write for those 5 cycles, grant held, abort 0, stream resumes with the correct next byte.
- Timeout: TIMEOUT=8, req1 drops after first byte -> abort pulses exactly 8 cycles later, grant 0, req3 pending is granted next cycle.
- Async reset asserted while STREAM grant=0100 -> grant, ack, fifo_write_flag at 0 immediately; after release, req2 and req0 both high -> req0 wins.
- With UART_ARB_HEADER_EN: req3 sends 0x5A (last) -> FIFO receives 0xA3 then 0x5A; ack3 high only on the second write.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_pkg
// Description : Shared state encodings, header marker and id-width helper.
// Revision    : 1.0
// ============================================================================
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    localparam logic [7:0] c_HDR_MARK = 8'hA0;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Requester byte streams plus TX FIFO write port.
// Revision    : 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   ack;
    logic               fifo_write_flag;
    logic [7:0]         fifo_data_in;
    logic               fifo_full_flag;

    // slave: the arbiter; master: requesters and FIFO seen as one driver
    modport slave (
        input  req, req_data, req_last, fifo_full_flag,
        output ack, fifo_write_flag, fifo_data_in
    );

    modport master (
        output req, req_data, req_last, fifo_full_flag,
        input  ack, fifo_write_flag, fifo_data_in
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin pick, search starts at i_ptr+1.
// Revision    : 1.0
// ============================================================================
module rr_priority_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [ID_W-1:0]  i_ptr,
    output logic      [N_REQ-1:0] o_winner,
    output logic      [ID_W-1:0]  o_idx,
    output logic                  o_any
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_winner = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = ID_W'((int'(i_ptr) + k) % N_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any            = 1'b1;
                o_winner[w_cand] = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Packet-granular round-robin arbiter onto one TX FIFO write
//               port. Define UART_ARB_HEADER_EN to prefix each packet with
//               an id header byte.
// Revision    : 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  wire logic             clock,
    input  wire logic             reset,
    uart_tx_arbiter_if.slave      bus,
    output logic      [N_REQ-1:0] grant,
    output logic                  busy,
    output logic                  abort
);

    localparam int ID_W  = id_width(N_REQ);
    localparam int TMO_W = $clog2(TIMEOUT);

`ifdef UART_ARB_HEADER_EN
    localparam state_t c_FIRST_STATE = ST_HEADER;
`else
    localparam state_t c_FIRST_STATE = ST_STREAM;
`endif

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    ptr_q,   ptr_d;
    logic [TMO_W-1:0]   tmo_q,   tmo_d;
    logic               abort_q, abort_d;
    logic [7:0]         data_q;

    logic [N_REQ-1:0]   w_win;
    logic [ID_W-1:0]    w_win_idx;
    logic               w_win_any;
    logic               w_own_req;
    logic               w_own_last;
    logic [7:0]         w_own_byte;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .i_req    (bus.req),
        .i_ptr    (ptr_q),
        .o_winner (w_win),
        .o_idx    (w_win_idx),
        .o_any    (w_win_any)
    );

    assign w_own_req  = bus.req[owner_q];
    assign w_own_last = bus.req_last[owner_q];
    assign w_own_byte = bus.req_data[{owner_q, 3'b000} +: 8];

    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        owner_d             = owner_q;
        ptr_d               = ptr_q;
        tmo_d               = tmo_q;
        abort_d             = 1'b0;
        bus.ack             = '0;
        bus.fifo_write_flag = 1'b0;
        bus.fifo_data_in    = data_q;

        case (state_q)
            ST_IDLE: begin
                // Selection cycle only: no byte moves until the grant is registered
                if (w_win_any) begin
                    grant_d = w_win;
                    owner_d = w_win_idx;
                    tmo_d   = '0;
                    state_d = c_FIRST_STATE;
                end
            end
`ifdef UART_ARB_HEADER_EN
            ST_HEADER: begin
                if (!bus.fifo_full_flag) begin
                    bus.fifo_write_flag = 1'b1;
                    bus.fifo_data_in    = c_HDR_MARK | 8'(owner_q);
                    tmo_d               = '0;
                    state_d             = ST_STREAM;
                end
            end
`endif
            ST_STREAM: begin
                if (w_own_req) begin
                    bus.fifo_data_in = w_own_byte;
                    if (!bus.fifo_full_flag) begin
                        bus.fifo_write_flag = 1'b1;
                        bus.ack[owner_q]    = 1'b1;
                        tmo_d               = '0;
                        if (w_own_last) begin
                            state_d = ST_IDLE;
                            grant_d = '0;
                            ptr_d   = owner_q;
                        end
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    // Owner went silent mid-packet: revoke, leave partial packet in FIFO
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = owner_q;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= ID_W'(N_REQ - 1);
            tmo_q   <= '0;
            abort_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
            abort_q <= abort_d;
            data_q  <= bus.fifo_data_in;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);
    assign abort = abort_q;

endmodule
`default_nettype wire
